// File: rtl/goose_pkg.sv
// Shared constants and types for the goose sprite renderer.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal flip toggled on each animation wrap).
package goose_pkg;

  localparam int SPRITE_W   = 32;
  localparam int SPRITE_H   = 32;
  localparam int NUM_FRAMES = 4;

  typedef logic [2:0] pal_idx_t;
  typedef logic [5:0] rgb222_t;

  // Index 0 is transparent and never looked up; its slot just mirrors the background.
  localparam rgb222_t BG_COLOR = 6'b01_01_11;
  localparam rgb222_t PALETTE [8] = '{
    6'b01_01_11, 6'b11_11_11, 6'b11_11_00, 6'b11_00_00,
    6'b10_10_10, 6'b11_10_00, 6'b00_00_11, 6'b00_11_00
  };

  typedef enum logic {
    HOLD = 1'b0,
    PLAY = 1'b1
  } anim_state_t;

endpackage

// File: rtl/goose_anim_ctrl.sv
// Animation sequencer: detects vsync edges, divides them down and steps frame_idx.
// With SPRITE_MIRROR_EN defined a mirror bit toggles each time frame_idx wraps 3->0.
module goose_anim_ctrl
  import goose_pkg::*;
#(
  parameter int FRAME_DIV = 6,
  parameter int SYNC_IDLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync_i,
  input  logic       anim_en,
  output logic [1:0] frame_idx_o
`ifdef SPRITE_MIRROR_EN
  ,
  output logic       mirror_o
`endif
);

  localparam logic       IDLE     = 1'(SYNC_IDLE);
  localparam logic [5:0] DIV_LAST = 6'(FRAME_DIV - 1);

  anim_state_t state_q, state_d;
  logic        vs_prev_q, vs_prev_d;
  logic [5:0]  div_q, div_d;
  logic [1:0]  frame_q, frame_d;
  logic        mirror_q, mirror_d;
  logic        vsync_edge;

  // Next-state: run/pause FSM plus vsync-paced divider and frame counter.
  always_comb begin
    state_d    = state_q;
    vs_prev_d  = vsync_i;
    div_d      = div_q;
    frame_d    = frame_q;
    mirror_d   = mirror_q;
    vsync_edge = (vs_prev_q == IDLE) && (vsync_i != IDLE);
    case (state_q)
      HOLD:    if (anim_en)  state_d = PLAY;
      PLAY:    if (!anim_en) state_d = HOLD;
      default: state_d = HOLD;
    endcase
    // Counter only moves on an edge while playing; a pause keeps its value.
    if (vsync_edge && (state_q == PLAY)) begin
      if (div_q >= DIV_LAST) begin
        div_d   = 6'd0;
        frame_d = frame_q + 2'd1;
        if (frame_q == 2'd3) mirror_d = ~mirror_q;
      end else begin
        div_d = div_q + 6'd1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= HOLD;
      vs_prev_q <= IDLE;
      div_q     <= 6'd0;
      frame_q   <= 2'd0;
      mirror_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      vs_prev_q <= vs_prev_d;
      div_q     <= div_d;
      frame_q   <= frame_d;
      mirror_q  <= mirror_d;
    end
  end

  assign frame_idx_o = frame_q;
`ifdef SPRITE_MIRROR_EN
  assign mirror_o = mirror_q;
`else
  // Without the flip feature the mirror bit is left for synthesis to remove.
  logic unused_mirror;
  assign unused_mirror = mirror_q;
`endif

endmodule

// File: rtl/goose_sprite_renderer.sv
// Two-stage sprite renderer: beam position -> LUT address (stage 1) -> palette RGB (stage 2).
// Syncs are delayed by the same two stages. Optional macro: SPRITE_MIRROR_EN.
module goose_sprite_renderer
  import goose_pkg::*;
#(
  parameter int SCALE_LOG2 = 2,
  parameter int FRAME_DIV  = 6,
  parameter int SYNC_IDLE  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic [9:0] sprite_x,
  input  logic [9:0] sprite_y,
  input  logic       anim_en,
  output logic [4:0] lut_x,
  output logic [4:0] lut_y,
  input  logic [2:0] pixel0,
  input  logic [2:0] pixel1,
  input  logic [2:0] pixel2,
  input  logic [2:0] pixel3,
  output logic [1:0] frame_idx,
  output logic [5:0] rgb,
  output logic       hsync_o,
  output logic       vsync_o
);

  localparam logic              IDLE  = 1'(SYNC_IDLE);
  localparam logic signed [10:0] BOX_W = 11'(SPRITE_W << SCALE_LOG2);
  localparam logic signed [10:0] BOX_H = 11'(SPRITE_H << SCALE_LOG2);

  logic [4:0] lut_x_q, lut_x_d, lut_y_q, lut_y_d;
  logic       in_box_q, in_box_d, disp1_q, disp1_d;
  logic       hs1_q, hs1_d, vs1_q, vs1_d, hs2_q, hs2_d, vs2_q, vs2_d;
  rgb222_t    rgb_q, rgb_d;
  logic signed [10:0] dx, dy;
  logic [4:0] col;
  pal_idx_t   idx;
  logic [1:0] frame_cur;
`ifdef SPRITE_MIRROR_EN
  logic       mirror;
`endif

  goose_anim_ctrl #(
    .FRAME_DIV(FRAME_DIV),
    .SYNC_IDLE(SYNC_IDLE)
  ) u_anim (
    .clk        (clk),
    .rst        (rst),
    .vsync_i    (vsync_i),
    .anim_en    (anim_en),
    .frame_idx_o(frame_cur)
`ifdef SPRITE_MIRROR_EN
    ,
    .mirror_o   (mirror)
`endif
  );

  // Stage 1: sprite-local offset, box test (unsigned-extended so no wrap) and LUT address.
  always_comb begin
    dx       = $signed({1'b0, hpos}) - $signed({1'b0, sprite_x});
    dy       = $signed({1'b0, vpos}) - $signed({1'b0, sprite_y});
    in_box_d = display_on && !dx[10] && (dx < BOX_W) && !dy[10] && (dy < BOX_H);
    col      = dx[SCALE_LOG2 +: 5];
    lut_x_d  = 5'd0;
    lut_y_d  = 5'd0;
    if (in_box_d) begin
`ifdef SPRITE_MIRROR_EN
      lut_x_d = mirror ? (5'd31 - col) : col;
`else
      lut_x_d = col;
`endif
      lut_y_d = dy[SCALE_LOG2 +: 5];
    end
    disp1_d = display_on;
    hs1_d   = hsync_i;
    vs1_d   = vsync_i;
  end

  // Stage 2: pick the active frame's palette index and map to RGB222.
  always_comb begin
    case (frame_cur)
      2'd0:    idx = pixel0;
      2'd1:    idx = pixel1;
      2'd2:    idx = pixel2;
      default: idx = pixel3;
    endcase
    if (!disp1_q)                       rgb_d = 6'd0;
    else if (!in_box_q || idx == 3'd0)  rgb_d = BG_COLOR;
    else                                rgb_d = PALETTE[idx];
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  // Pipeline registers with synchronous reset to idle/blank values.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut_x_q  <= 5'd0;
      lut_y_q  <= 5'd0;
      in_box_q <= 1'b0;
      disp1_q  <= 1'b0;
      hs1_q    <= IDLE;
      vs1_q    <= IDLE;
      hs2_q    <= IDLE;
      vs2_q    <= IDLE;
      rgb_q    <= 6'd0;
    end else begin
      lut_x_q  <= lut_x_d;
      lut_y_q  <= lut_y_d;
      in_box_q <= in_box_d;
      disp1_q  <= disp1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb_q    <= rgb_d;
    end
  end

  assign lut_x     = lut_x_q;
  assign lut_y     = lut_y_q;
  assign frame_idx = frame_cur;
  assign rgb       = rgb_q;
  assign hsync_o   = hs2_q;
  assign vsync_o   = vs2_q;

endmodule

// File: tb/tb_goose_sprite_renderer.sv
// Bench for goose_sprite_renderer (SCALE_LOG2=2, FRAME_DIV=2, SYNC_IDLE=1).
// Honours SPRITE_MIRROR_EN when defined for both DUT and reference model.
module tb_goose_sprite_renderer;

  localparam int SCALE_LOG2 = 2;
  localparam int FRAME_DIV  = 2;
  localparam int SPAN       = 32 * (1 << SCALE_LOG2);
  localparam logic [5:0] BG = 6'b01_01_11;
  localparam logic [5:0] PAL [8] = '{
    6'b01_01_11, 6'b11_11_11, 6'b11_11_00, 6'b11_00_00,
    6'b10_10_10, 6'b11_10_00, 6'b00_00_11, 6'b00_11_00
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] hpos = '0, vpos = '0, sprite_x = '0, sprite_y = '0;
  logic display_on = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1, anim_en = 1'b0;
  logic [4:0] lut_x, lut_y;
  logic [2:0] pixel0, pixel1, pixel2, pixel3;
  logic [1:0] frame_idx;
  logic [5:0] rgb;
  logic hsync_o, vsync_o;

  // Behavioural LUT contents: some hash of (frame, x, y) giving all indices 0..7.
  function automatic logic [2:0] rom(input int k, input logic [4:0] x, input logic [4:0] y);
    int v;
    v = int'(x) * 3 + int'(y) * 5 + k * 7 + int'(x & y);
    return 3'(v % 8);
  endfunction

  assign pixel0 = rom(0, lut_x, lut_y);
  assign pixel1 = rom(1, lut_x, lut_y);
  assign pixel2 = rom(2, lut_x, lut_y);
  assign pixel3 = rom(3, lut_x, lut_y);

  goose_sprite_renderer #(.SCALE_LOG2(SCALE_LOG2), .FRAME_DIV(FRAME_DIV), .SYNC_IDLE(1)) dut (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .anim_en(anim_en), .lut_x(lut_x), .lut_y(lut_y), .pixel0(pixel0), .pixel1(pixel1),
    .pixel2(pixel2), .pixel3(pixel3), .frame_idx(frame_idx), .rgb(rgb),
    .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state: counts of qualifying vsync edges drive frame and mirror.
  typedef struct {
    logic [4:0] lx, ly;
    logic       inb, disp, hs, vs;
  } s1_t;

  s1_t  p1;
  int   en_edges;
  logic prev_vs, en_prev;
  int   frame_m;
  logic mir_m;
  logic [5:0] exp_q[$];

  task automatic model_reset();
    en_edges = 0;
    prev_vs  = 1'b1;
    en_prev  = 1'b0;
    frame_m  = 0;
    mir_m    = 1'b0;
    p1       = '{lx: 5'd0, ly: 5'd0, inb: 1'b0, disp: 1'b0, hs: 1'b1, vs: 1'b1};
  endtask

  // One clock: predict outputs from the applied inputs, advance, then compare.
  task automatic tick();
    s1_t e1;
    int dx, dy;
    logic [2:0] pix;
    logic [5:0] erg;
    dx     = int'(hpos) - int'(sprite_x);
    dy     = int'(vpos) - int'(sprite_y);
    e1.inb = display_on && dx >= 0 && dx < SPAN && dy >= 0 && dy < SPAN;
    e1.lx  = e1.inb ? 5'(dx / (1 << SCALE_LOG2)) : 5'd0;
    e1.ly  = e1.inb ? 5'(dy / (1 << SCALE_LOG2)) : 5'd0;
    if (e1.inb && mir_m) e1.lx = 5'd31 - e1.lx;
    e1.disp = display_on;
    e1.hs   = hsync_i;
    e1.vs   = vsync_i;
    pix = rom(frame_m, p1.lx, p1.ly);
    erg = !p1.disp ? 6'd0 : (!p1.inb || pix == 3'd0) ? BG : PAL[pix];
    exp_q.push_back(erg);
    if (prev_vs && !vsync_i && en_prev) en_edges++;
    prev_vs  = vsync_i;
    en_prev  = anim_en;
    frame_m  = (en_edges / FRAME_DIV) % 4;
`ifdef SPRITE_MIRROR_EN
    mir_m    = 1'((en_edges / (FRAME_DIV * 4)) % 2);
`else
    mir_m    = 1'b0;
`endif
    @(posedge clk);
    #1;
    chk("lut_x", lut_x, e1.lx);
    chk("lut_y", lut_y, e1.ly);
    chk("rgb", rgb, exp_q.pop_front());
    chk("hsync_o", hsync_o, p1.hs);
    chk("vsync_o", vsync_o, p1.vs);
    chk("frame_idx", frame_idx, frame_m);
    p1 = e1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic rand_pixel();
    hpos       = 10'(int'(sprite_x) - 8 + int'($urandom_range(0, 150)));
    vpos       = 10'(int'(sprite_y) - 8 + int'($urandom_range(0, 150)));
    display_on = ($urandom_range(0, 9) != 0);
    hsync_i    = ($urandom_range(0, 7) != 0);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      rand_pixel();
      vsync_i = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      chk("rst_rgb", rgb, 0);
      chk("rst_lut_x", lut_x, 0);
      chk("rst_lut_y", lut_y, 0);
      chk("rst_frame", frame_idx, 0);
      chk("rst_hsync", hsync_o, 1);
      chk("rst_vsync", vsync_o, 1);
    end
    rst     = 1'b0;
    vsync_i = 1'b1;
    exp_q.delete();
    model_reset();
  endtask

  // One video frame: pixels with vsync idle, a 2-cycle vsync pulse, then idle gap.
  task automatic run_frame(input logic en, input int n_pix);
    anim_en = en;
    vsync_i = 1'b1;
    for (int i = 0; i < n_pix; i++) begin
      rand_pixel();
      tick();
    end
    vsync_i = 1'b0;
    rand_pixel(); display_on = 1'b0; tick();
    rand_pixel(); display_on = 1'b0; tick();
    vsync_i = 1'b1;
    rand_pixel(); tick();
    rand_pixel(); tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] mir_exp;
    model_reset();
    sprite_x = 10'd300;
    sprite_y = 10'd200;
    do_reset(3);

    // Address mapping and background around a sprite at (100,50).
    sprite_x = 10'd100; sprite_y = 10'd50; display_on = 1'b1; hsync_i = 1'b1;
    hpos = 10'd100; vpos = 10'd50; tick();
    chk("t2_lx_origin", lut_x, 0);
    chk("t2_ly_origin", lut_y, 0);
    hpos = 10'd107; vpos = 10'd61; tick();
    chk("t2_lx_1", lut_x, 1);
    chk("t2_ly_2", lut_y, 2);
    hpos = 10'd228; tick();
    hpos = 10'd99;  tick();
    chk("t2_bg_right", rgb, BG);
    hpos = 10'd150; tick();
    chk("t2_bg_left", rgb, BG);

    // Steady animation: frame steps every FRAME_DIV edges and wraps.
    for (int f = 1; f <= 16; f++) begin
      run_frame(1'b1, 12);
      if (f == 2) chk("t3_after2", frame_idx, 1);
      if (f == 6) chk("t3_after6", frame_idx, 3);
      if (f == 8 || f == 16) begin
        chk("t3_wrap", frame_idx, 0);
`ifdef SPRITE_MIRROR_EN
        mir_exp = (f == 8) ? 5'd31 : 5'd0;
`else
        mir_exp = 5'd0;
`endif
        hpos = sprite_x; vpos = sprite_y; display_on = 1'b1; tick();
        chk("t6_mirror", lut_x, mir_exp);
      end
    end

    // Pause after 3 edges, then resume.
    do_reset(2);
    sprite_x = 10'd400; sprite_y = 10'd300;
    for (int f = 0; f < 3; f++) run_frame(1'b1, 10);
    for (int f = 0; f < 10; f++) begin
      run_frame(1'b0, 10);
      chk("t4_frozen", frame_idx, 1);
    end
    run_frame(1'b1, 10);
    chk("t4_resume", frame_idx, 2);

    // Random positions (including right/bottom clipping) with random pausing and a mid-frame reset.
    for (int f = 0; f < 40; f++) begin
      sprite_x = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(900, 1023)) : 10'($urandom_range(0, 800));
      sprite_y = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(900, 1023)) : 10'($urandom_range(0, 800));
      if (f == 20) begin
        for (int i = 0; i < 5; i++) begin
          rand_pixel();
          tick();
        end
        do_reset(3);
      end
      run_frame(1'($urandom_range(0, 3) != 0), int'($urandom_range(20, 80)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
